iob_pfsm_timed: RTL and testbench

Programmable finite-state machine with per-state dwell timers, run/stop/single-step control and optional auto-halt. It is the next generation of the IOb PFSM peripheral: the transition/output LUT is kept, and three things are added: a second table of per-state dwell counts, registered outputs and a transition counter. It sits behind a register-file front end, which drives the table write ports and control strobes, and drives output ports toward the SoC pads or other cores.

---
 rtl/iob_pfsm_timed.sv | 120 ++++++++++++
 tb/tb_iob_pfsm_timed.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iob_pfsm_timed.sv
// Programmable FSM: {state,input} -> {next_state,output} LUT, per-state dwell
// counts, run/stop/single-step control, optional auto-halt on the last state.
module iob_pfsm_timed #(
  parameter int STATE_W   = 2,
  parameter int INPUT_W   = 1,
  parameter int OUTPUT_W  = 1,
  parameter int CNT_W     = 16,
  parameter bit AUTO_HALT = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cke_i,
  input  logic                    lut_we_i,
  input  logic [STATE_W+INPUT_W-1:0]  lut_addr_i,
  input  logic [STATE_W+OUTPUT_W-1:0] lut_wdata_i,
  input  logic                    dwell_we_i,
  input  logic [STATE_W-1:0]      dwell_addr_i,
  input  logic [CNT_W-1:0]        dwell_wdata_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    step_i,
  input  logic [INPUT_W-1:0]      input_i,
  output logic [OUTPUT_W-1:0]     output_o,
  output logic [STATE_W-1:0]      state_o,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [CNT_W-1:0]        trans_o,
  output logic                    running_o,
  output logic                    halt_o
);

  localparam int LUT_D   = 2**(STATE_W+INPUT_W);
  localparam int DWELL_D = 2**STATE_W;
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [STATE_W-1:0] LAST_STATE = '1;

  typedef struct packed {
    logic [STATE_W-1:0]  nxt;
    logic [OUTPUT_W-1:0] out;
  } lut_word_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ctrl_t;

  lut_word_t            lut   [LUT_D];
  logic [CNT_W-1:0]     dwell [DWELL_D];

  ctrl_t                ctrl_q, ctrl_d;
  logic [STATE_W-1:0]   state_q;
  logic [OUTPUT_W-1:0]  out_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     trans_q;
  logic                 halt_q;

  lut_word_t            w;
  logic [CNT_W-1:0]     dwell_rd;
  logic                 eval_run, eval_step, eval, halt_hit;

  // Table reads are combinational off the registered arrays, so a same-cycle
  // write is seen only from the next cycle on.
  always_comb begin
    w         = lut[{state_q, input_i}];
    dwell_rd  = dwell[w.nxt];
    eval_run  = (ctrl_q == RUN) && (cnt_q == '0);
    eval_step = (ctrl_q == IDLE) && step_i && !start_i;
    eval      = eval_run || eval_step;
    halt_hit  = AUTO_HALT && eval_run && (w.nxt == LAST_STATE);
  end

  // Control FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i)      ctrl_q <= IDLE;
    else if (cke_i) ctrl_q <= ctrl_d;
  end

  // Control FSM: next state; stop wins over start
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      IDLE:    if (start_i && !stop_i)   ctrl_d = RUN;
      RUN:     if (stop_i || halt_hit)   ctrl_d = IDLE;
      default: ctrl_d = IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    running_o = (ctrl_q == RUN);
  end

  // Datapath and tables
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      trans_q <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < LUT_D; i++)   lut[i]   <= '0;
      for (int i = 0; i < DWELL_D; i++) dwell[i] <= '0;
    end else if (cke_i) begin
      if (lut_we_i)   lut[lut_addr_i]     <= lut_word_t'(lut_wdata_i);
      if (dwell_we_i) dwell[dwell_addr_i] <= dwell_wdata_i;
      halt_q <= halt_hit;
      if (eval) begin
        state_q <= w.nxt;
        out_q   <= w.out;
        cnt_q   <= dwell_rd;
        if (trans_q != '1) trans_q <= trans_q + CNT_ONE;
      end else if (ctrl_q == RUN && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign output_o = out_q;
  assign state_o  = state_q;
  assign cnt_o    = cnt_q;
  assign trans_o  = trans_q;
  assign halt_o   = halt_q;

endmodule

// File: tb/tb_iob_pfsm_timed.sv
// Directed bench for iob_pfsm_timed (CNT_W=4 so trans saturation is reachable).
module tb_iob_pfsm_timed;
  localparam int STATE_W = 2, INPUT_W = 1, OUTPUT_W = 1, CNT_W = 4;

  logic clk = 1'b0, rst = 1'b0, cke = 1'b1;
  logic lut_we = 1'b0, dwell_we = 1'b0;
  logic [STATE_W+INPUT_W-1:0]  lut_addr = '0;
  logic [STATE_W+OUTPUT_W-1:0] lut_wdata = '0;
  logic [STATE_W-1:0]          dwell_addr = '0;
  logic [CNT_W-1:0]            dwell_wdata = '0;
  logic start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [INPUT_W-1:0]  in_v = '0;
  logic [OUTPUT_W-1:0] out_v;
  logic [STATE_W-1:0]  state;
  logic [CNT_W-1:0]    cnt, trans;
  logic running, halt;

  int n_chk = 0, n_pass = 0;

  iob_pfsm_timed #(.STATE_W(STATE_W), .INPUT_W(INPUT_W), .OUTPUT_W(OUTPUT_W),
                   .CNT_W(CNT_W), .AUTO_HALT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .lut_we_i(lut_we), .lut_addr_i(lut_addr), .lut_wdata_i(lut_wdata),
    .dwell_we_i(dwell_we), .dwell_addr_i(dwell_addr), .dwell_wdata_i(dwell_wdata),
    .start_i(start), .stop_i(stop), .step_i(step), .input_i(in_v),
    .output_o(out_v), .state_o(state), .cnt_o(cnt), .trans_o(trans),
    .running_o(running), .halt_o(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic lut_wr(input logic [2:0] a, input logic [2:0] d);
    lut_we = 1'b1; lut_addr = a; lut_wdata = d; tick(); lut_we = 1'b0;
  endtask

  task automatic dwell_wr(input logic [1:0] a, input logic [3:0] d);
    dwell_we = 1'b1; dwell_addr = a; dwell_wdata = d; tick(); dwell_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  int exp_o [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int exp_t [10] = '{1, 1, 1, 1, 2, 3, 3, 3, 3, 4};

  initial begin
    tick();
    // Reset values
    do_reset();
    chk("rst_out", out_v, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_trans", trans, 0);
    chk("rst_running", running, 0);
    chk("rst_halt", halt, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("step0_state", state, 0);
    chk("step0_trans", trans, 1);
    chk("step0_out", out_v, 0);

    // Two-state toggler: 0 -> {1,out1} (dwell 3) -> {0,out0} (dwell 0)
    do_reset();
    lut_wr(3'b000, 3'b011); lut_wr(3'b001, 3'b011);
    lut_wr(3'b010, 3'b000); lut_wr(3'b011, 3'b000);
    dwell_wr(2'd1, 4'd3);
    pulse_start();
    chk("tog_running", running, 1);
    chk("tog_trans0", trans, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("tog_out%0d", i), out_v, exp_o[i]);
      chk($sformatf("tog_trans%0d", i), trans, exp_t[i]);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("tog_stopped", running, 0);

    // Input-conditioned branch: {0,1} -> {2,out1}
    do_reset();
    lut_wr(3'b001, 3'b101);
    in_v = 1'b0;
    pulse_start();
    tick(5);
    chk("br_hold_state", state, 0);
    chk("br_hold_trans", trans, 5);
    in_v = 1'b1; tick();
    chk("br_state", state, 2);
    chk("br_out", out_v, 1);
    in_v = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // Auto-halt along 0 -> 1 -> 3
    do_reset();
    lut_wr(3'b000, 3'b010); lut_wr(3'b001, 3'b010);
    lut_wr(3'b010, 3'b111); lut_wr(3'b011, 3'b111);
    pulse_start();
    tick();
    chk("ah_state1", state, 1);
    chk("ah_run1", running, 1);
    tick();
    chk("ah_state3", state, 3);
    chk("ah_run_drop", running, 0);
    chk("ah_halt_hi", halt, 1);
    tick();
    chk("ah_halt_lo", halt, 0);
    chk("ah_state_hold", state, 3);
    step = 1'b1; tick(); step = 1'b0;
    chk("ah_step_state", state, 0);
    chk("ah_step_trans", trans, 3);
    // Stepping back into state 3 does not pulse halt
    step = 1'b1; tick(); step = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    chk("ah_step3_state", state, 3);
    chk("ah_step3_halt", halt, 0);

    // Strobe conflicts
    do_reset();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("cf_start_stop", running, 0);
    lut_wr(3'b000, 3'b010); lut_wr(3'b001, 3'b010);
    dwell_wr(2'd1, 4'd5);
    pulse_start();
    tick();
    chk("cf_state1", state, 1);
    chk("cf_cnt5", cnt, 5);
    step = 1'b1; tick(); step = 1'b0;
    chk("cf_step_trans", trans, 1);
    chk("cf_step_cnt", cnt, 4);
    tick(4);
    chk("cf_cnt0", cnt, 0);
    // Evaluation this cycle reads {1,0}; a write there now must not be used
    lut_wr(3'b010, 3'b100);
    chk("cf_old_word", state, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // cke low mid-dwell freezes the count and drops writes
    do_reset();
    lut_wr(3'b000, 3'b010); lut_wr(3'b001, 3'b010);
    dwell_wr(2'd1, 4'd8);
    pulse_start();
    tick(2);
    chk("ck_cnt7", cnt, 7);
    cke = 1'b0;
    lut_we = 1'b1; lut_addr = 3'b010; lut_wdata = 3'b101;
    tick(10);
    lut_we = 1'b0;
    chk("ck_frozen", cnt, 7);
    chk("ck_state", state, 1);
    cke = 1'b1;
    tick(8);
    chk("ck_write_lost", state, 0);
    chk("ck_out", out_v, 0);

    // Reset mid-run clears outputs and tables
    tick(3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_running", running, 0);
    chk("mr_state", state, 0);
    chk("mr_trans", trans, 0);
    step = 1'b1; tick(); step = 1'b0;
    chk("mr_lut_clear", state, 0);
    chk("mr_dwell_clear", cnt, 0);

    // trans saturation at 15
    do_reset();
    step = 1'b1; tick(14);
    chk("sat_14", trans, 14);
    tick(6); step = 1'b0;
    chk("sat_15", trans, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
